// File: rtl/proc_pkg.sv
// Shared definitions for the processor sequencer: opcodes, FSM states,
// instruction classes, register-write source codes and instruction field positions.
package proc_pkg;

    localparam logic [3:0] OP_LDI = 4'b1000;
    localparam logic [3:0] OP_LDM = 4'b1001;
    localparam logic [3:0] OP_ST  = 4'b1010;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_IMM = 2'b01;
    localparam logic [1:0] WSEL_MEM = 2'b10;

    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int ALUOP_MSB = 14;
    localparam int ALUOP_LSB = 12;
    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 9;
    localparam int RS1_MSB   = 8;
    localparam int RS1_LSB   = 6;
    localparam int RS2_MSB   = 5;
    localparam int RS2_LSB   = 3;
    localparam int IMM_MSB   = 7;
    localparam int IMM_LSB   = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LDI,
        CL_LDM,
        CL_ST,
        CL_HLT,
        CL_ILL
    } iclass_t;

endpackage

// File: rtl/proc_sequencer_if.sv
// Bus between the sequencer (master) and the instruction ROM / regfile / ALU /
// data memory (slave).
interface proc_sequencer_if #(
    parameter int PC_W    = 3,
    parameter int DADDR_W = 8
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [15:0]        imem_rdata;
    logic [2:0]         rf_raddr1;
    logic [2:0]         rf_raddr2;
    logic [2:0]         alu_op;
    logic               alu_en;
    logic               rf_we;
    logic [2:0]         rf_waddr;
    logic [1:0]         rf_wsel;
    logic               dmem_req;
    logic               dmem_we;
    logic [DADDR_W-1:0] dmem_addr;
    logic               dmem_ack;

    modport master (
        output imem_req, imem_addr, rf_raddr1, rf_raddr2, alu_op, alu_en,
               rf_we, rf_waddr, rf_wsel, dmem_req, dmem_we, dmem_addr,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, rf_raddr1, rf_raddr2, alu_op, alu_en,
               rf_we, rf_waddr, rf_wsel, dmem_req, dmem_we, dmem_addr,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/proc_decode.sv
// Combinational instruction decoder: classifies the latched instruction and
// extracts operand/destination/address fields.
module proc_decode
    import proc_pkg::*;
(
    input  logic [15:0] ir,
    output iclass_t     iclass,
    output logic [2:0]  alu_op,
    output logic [2:0]  raddr1,
    output logic [2:0]  raddr2,
    output logic [2:0]  waddr,
    output logic [7:0]  daddr,
    output logic        illegal
);
    logic [3:0] opcode;

    assign opcode = ir[OPC_MSB:OPC_LSB];

    always_comb begin
        iclass = CL_ILL;
        if (opcode[3:2] == 2'b00) begin
            iclass = CL_ALU;
        end else begin
            case (opcode)
                OP_LDI:  iclass = CL_LDI;
                OP_LDM:  iclass = CL_LDM;
                OP_ST:   iclass = CL_ST;
                OP_HLT:  iclass = CL_HLT;
                default: iclass = CL_ILL;
            endcase
        end
    end

    assign alu_op  = ir[ALUOP_MSB:ALUOP_LSB];
    assign raddr1  = ir[RS1_MSB:RS1_LSB];
    // A store reads the register named in the destination field as its data source.
    assign raddr2  = (iclass == CL_ST) ? ir[RD_MSB:RD_LSB] : ir[RS2_MSB:RS2_LSB];
    assign waddr   = ir[RD_MSB:RD_LSB];
    assign daddr   = ir[IMM_MSB:IMM_LSB];
    assign illegal = (iclass == CL_ILL);

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM; owns the PC and instruction register.
// Build macro SEQ_SINGLE_STEP_EN adds a step input: one instruction per rising edge of step.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int PC_W    = 3,
    parameter int DADDR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    proc_sequencer_if.master bus,
    output logic             illegal,
    output logic             halted
);
    state_t          state;
    state_t          state_nx;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    iclass_t         iclass;
    logic [2:0]      alu_op;
    logic [2:0]      raddr1;
    logic [2:0]      raddr2;
    logic [2:0]      waddr;
    logic [7:0]      daddr;
    logic            dec_illegal;
    logic            start;
    logic            boundary_run;

    proc_decode u_decode (
        .ir      (ir),
        .iclass  (iclass),
        .alu_op  (alu_op),
        .raddr1  (raddr1),
        .raddr2  (raddr2),
        .waddr   (waddr),
        .daddr   (daddr),
        .illegal (dec_illegal)
    );

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) step_q <= 1'b0;
        else        step_q <= step;
    end

    // Every boundary parks in IDLE; only a fresh step edge launches the next instruction.
    assign start        = run && step && !step_q;
    assign boundary_run = 1'b0;
`else
    assign start        = run;
    assign boundary_run = run;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == S_FETCH && bus.imem_ack) begin
                ir <= bus.imem_rdata;
                pc <= pc + PC_W'(1);
            end
        end
    end

    always_comb begin
        state_nx     = state;
        bus.imem_req = 1'b0;
        bus.alu_en   = 1'b0;
        bus.rf_we    = 1'b0;
        bus.dmem_req = 1'b0;
        illegal      = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nx = S_FETCH;
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) state_nx = S_DECODE;
            end
            S_DECODE: begin
                case (iclass)
                    CL_ALU:        state_nx = S_EXEC;
                    CL_LDI:        state_nx = S_WB;
                    CL_LDM, CL_ST: state_nx = S_MEM;
                    CL_HLT:        state_nx = S_HALT;
                    default: begin
                        illegal  = dec_illegal;
                        state_nx = boundary_run ? S_FETCH : S_IDLE;
                    end
                endcase
            end
            S_EXEC: begin
                bus.alu_en = 1'b1;
                state_nx   = S_WB;
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                if (bus.dmem_ack) state_nx = S_WB;
            end
            // Stores also pass through WB (without writing) to keep memory ops at equal latency.
            S_WB: begin
                bus.rf_we = (iclass != CL_ST);
                state_nx  = boundary_run ? S_FETCH : S_IDLE;
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.imem_addr = pc;
    assign bus.rf_raddr1 = raddr1;
    assign bus.rf_raddr2 = raddr2;
    assign bus.alu_op    = alu_op;
    assign bus.rf_waddr  = waddr;
    assign bus.rf_wsel   = (iclass == CL_LDI) ? WSEL_IMM :
                           (iclass == CL_LDM) ? WSEL_MEM : WSEL_ALU;
    assign bus.dmem_we   = (state == S_MEM) && (iclass == CL_ST);
    assign bus.dmem_addr = DADDR_W'(daddr);
    assign halted        = (state == S_HALT);

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: directed timing scenarios plus random programs
// compared against an instruction-level event model.
module tb_proc_sequencer;
    import proc_pkg::*;

    localparam int PC_W    = 3;
    localparam int DADDR_W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic run   = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic step  = 1'b0;
`endif
    logic illegal;
    logic halted;

    proc_sequencer_if #(.PC_W(PC_W), .DADDR_W(DADDR_W)) bus ();

    proc_sequencer #(.PC_W(PC_W), .DADDR_W(DADDR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step    (step),
`endif
        .bus     (bus),
        .illegal (illegal),
        .halted  (halted)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [15:0] rom [8];
    int  i_hi    = 0;
    int  d_lo    = 0;
    int  d_hi    = 0;
    bit  d_en    = 1'b1;
    bit  d_stray = 1'b0;
    bit  mon_en  = 1'b0;
    int  ic = 0, iw = 0, dc = 0, dw = 0;
    logic [31:0] ev_q [$];

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory responders: ack after a chosen number of wait cycles, drawn when a request starts.
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ack   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.imem_req) begin
                if (ic == 0) iw = int'($urandom_range(i_hi, 0));
                if (ic >= iw) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = rom[bus.imem_addr];
                    ic = 0;
                end else begin
                    bus.imem_ack = 1'b0;
                    ic++;
                end
            end else begin
                bus.imem_ack = 1'b0;
                ic = 0;
            end
            if (!d_en) begin
                bus.dmem_ack = d_stray;
                dc = 0;
            end else if (bus.dmem_req) begin
                if (dc == 0) dw = int'($urandom_range(d_hi, d_lo));
                if (dc >= dw) begin
                    bus.dmem_ack = 1'b1;
                    dc = 0;
                end else begin
                    bus.dmem_ack = 1'b0;
                    dc++;
                end
            end else begin
                bus.dmem_ack = 1'b0;
                dc = 0;
            end
        end
    end

    function automatic logic [31:0] ev(input logic [3:0] k, input logic [15:0] pl);
        return {k, 12'h000, pl};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.imem_req && bus.imem_ack) ev_q.push_back(ev(4'd1, 16'(bus.imem_addr)));
            if (bus.alu_en) ev_q.push_back(ev(4'd2, {7'd0, bus.alu_op, bus.rf_raddr1, bus.rf_raddr2}));
            if (bus.rf_we)  ev_q.push_back(ev(4'd3, {11'd0, bus.rf_waddr, bus.rf_wsel}));
            if (bus.dmem_req && bus.dmem_ack)
                ev_q.push_back(ev(4'd4, {4'd0, bus.dmem_we, bus.dmem_addr,
                                         (bus.dmem_we ? bus.rf_raddr2 : 3'd0)}));
            if (illegal) ev_q.push_back(ev(4'd5, 16'd1));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        run   = 1'b0;
        reset = 1'b0;
        tick(2);
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < 8; i++) rom[i] = w;
    endtask

    initial begin
        logic [15:0] w;
        logic [3:0]  op;
        logic [3:0]  ill_ops [8];
        logic [31:0] exp_q [$];
        int          st;
        int          guard;
        int          cls;
        int          n_we;

        ill_ops = '{4'h4, 4'h5, 4'h6, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE};

        // Reset state
        fill_rom(16'hF000);
        reset_dut();
        chk("rst imem_req",  bus.imem_req,  0);
        chk("rst imem_addr", bus.imem_addr, 0);
        chk("rst alu_en",    bus.alu_en,    0);
        chk("rst rf_we",     bus.rf_we,     0);
        chk("rst rf_wsel",   bus.rf_wsel,   0);
        chk("rst rf_waddr",  bus.rf_waddr,  0);
        chk("rst alu_op",    bus.alu_op,    0);
        chk("rst dmem_req",  bus.dmem_req,  0);
        chk("rst dmem_we",   bus.dmem_we,   0);
        chk("rst dmem_addr", bus.dmem_addr, 0);
        chk("rst illegal",   illegal,       0);
        chk("rst halted",    halted,        0);

        // Program LDI r0,7; LDI r1,2; ADD r7,r0,r1; HLT with zero-wait acks
        rom[0] = 16'h8007; rom[1] = 16'h8202; rom[2] = 16'h0E08; rom[3] = 16'hF000;
        run = 1'b1; reset = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick(1);
            chk($sformatf("t1 rf_we c%0d", c), bus.rf_we, (c == 3 || c == 6 || c == 10));
            chk($sformatf("t1 alu_en c%0d", c), bus.alu_en, (c == 9));
            if (c == 3)  begin chk("t1 waddr c3", bus.rf_waddr, 0); chk("t1 wsel c3", bus.rf_wsel, 1); end
            if (c == 6)  chk("t1 waddr c6", bus.rf_waddr, 1);
            if (c == 10) begin
                chk("t1 waddr c10", bus.rf_waddr, 7);
                chk("t1 wsel c10",  bus.rf_wsel,  0);
                chk("t1 alu_op c10", bus.alu_op,  0);
            end
        end
        chk("t1 halted", halted, 1);
        chk("t1 pc", bus.imem_addr, 4);
        run = 1'b0;
        tick(3);
        chk("t1 halt sticky", halted, 1);
        chk("t1 no fetch in halt", bus.imem_req, 0);

        // STORE r7 -> 0xFF with three data wait cycles
        fill_rom(16'h8007);
        rom[0] = 16'hAEFF;
        d_lo = 3; d_hi = 3;
        reset_dut();
        run = 1'b1; reset = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick(1);
            chk($sformatf("t2 dmem_req c%0d", c), bus.dmem_req, (c >= 3 && c <= 6));
            chk($sformatf("t2 rf_we c%0d", c), bus.rf_we, 0);
            if (c >= 3 && c <= 6) begin
                chk($sformatf("t2 dmem_we c%0d", c), bus.dmem_we, 1);
                chk($sformatf("t2 dmem_addr c%0d", c), bus.dmem_addr, 8'hFF);
                chk($sformatf("t2 raddr2 c%0d", c), bus.rf_raddr2, 7);
            end
            if (c == 8) begin
                chk("t2 imem_req resumes", bus.imem_req, 1);
                chk("t2 imem_addr", bus.imem_addr, 1);
            end
        end
        d_lo = 0; d_hi = 0;

        // Undefined opcodes 0x5xxx and 0xCxxx
        fill_rom(16'h8101);
        rom[0] = 16'h5123; rom[1] = 16'hC456;
        reset_dut();
        run = 1'b1; reset = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick(1);
            chk($sformatf("t3 illegal c%0d", c), illegal, (c == 2 || c == 4));
            chk($sformatf("t3 rf_we c%0d", c), bus.rf_we, (c == 7));
            chk($sformatf("t3 dmem_req c%0d", c), bus.dmem_req, 0);
            if (c == 3) chk("t3 pc after first", bus.imem_addr, 1);
            if (c == 5) chk("t3 pc after second", bus.imem_addr, 2);
        end

        // Eight ALU words: ninth fetch wraps to address 0
        fill_rom(16'h1000);
        reset_dut();
        run = 1'b1; reset = 1'b1;
        tick(1);
        for (int k = 0; k <= 8; k++) begin
            chk($sformatf("t4 imem_req f%0d", k), bus.imem_req, 1);
            chk($sformatf("t4 imem_addr f%0d", k), bus.imem_addr, k % 8);
            tick(4);
        end

        // Reset while a data request is outstanding
        fill_rom(16'h1000);
        rom[0] = 16'h9010;
        d_lo = 50; d_hi = 50;
        reset_dut();
        run = 1'b1; reset = 1'b1;
        tick(4);
        chk("t5 dmem_req before reset", bus.dmem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5 dmem_req drops async", bus.dmem_req, 0);
        d_en = 1'b0; d_stray = 1'b1;
        tick(1);
        chk("t5 stray ack rf_we", bus.rf_we, 0);
        chk("t5 stray ack dmem_req", bus.dmem_req, 0);
        chk("t5 ir cleared", bus.dmem_addr, 0);
        reset = 1'b1;
        tick(1);
        chk("t5 refetch req", bus.imem_req, 1);
        chk("t5 refetch addr", bus.imem_addr, 0);
        chk("t5 rf_we after stray", bus.rf_we, 0);
        d_en = 1'b1; d_stray = 1'b0; d_lo = 0; d_hi = 0;
        tick(2);
        chk("t5 reload dmem_addr", bus.dmem_addr, 8'h10);
        chk("t5 reload dmem_we", bus.dmem_we, 0);
        tick(1);
        chk("t5 reload rf_we", bus.rf_we, 1);
        chk("t5 reload wsel", bus.rf_wsel, 2);

        // run dropped while an ALU instruction is in flight
        fill_rom(16'h1E08);
        reset_dut();
        run = 1'b1; reset = 1'b1;
        tick(2);
        run = 1'b0;
        tick(2);
        chk("t6 rf_we completes", bus.rf_we, 1);
        chk("t6 waddr", bus.rf_waddr, 7);
        for (int c = 5; c <= 8; c++) begin
            tick(1);
            chk($sformatf("t6 idle imem_req c%0d", c), bus.imem_req, 0);
            chk($sformatf("t6 idle rf_we c%0d", c), bus.rf_we, 0);
        end
        chk("t6 pc held", bus.imem_addr, 1);
`ifdef SEQ_SINGLE_STEP_EN
        run = 1'b1;
        tick(3);
        chk("t6 waits for step", bus.imem_req, 0);
        step = 1'b1;
        n_we = 0;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (bus.rf_we) n_we++;
        end
        step = 1'b0;
        chk("t6 one step one write", n_we, 1);
        chk("t6 parked after step", bus.imem_req, 0);
`else
        run = 1'b1;
        tick(1);
        chk("t6 resume fetch", bus.imem_req, 1);
        n_we = 0;
`endif

        // Random programs against an instruction-level event model
        i_hi = 2; d_lo = 0; d_hi = 3;
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 7; p++) begin
                cls = int'($urandom_range(4, 0));
                w   = 16'($urandom);
                case (cls)
                    0:       op = 4'($urandom_range(3, 0));
                    1:       op = 4'h8;
                    2:       op = 4'h9;
                    3:       op = 4'hA;
                    default: op = ill_ops[$urandom_range(7, 0)];
                endcase
                w[15:12] = op;
                rom[p]   = w;
            end
            rom[7] = 16'hF000;

            exp_q.delete();
            for (int p = 0; p < 8; p++) begin
                w = rom[p];
                exp_q.push_back(ev(4'd1, 16'(p)));
                if (w[15:12] < 4'h4) begin
                    exp_q.push_back(ev(4'd2, {7'd0, w[14:12], w[8:6], w[5:3]}));
                    exp_q.push_back(ev(4'd3, {11'd0, w[11:9], 2'b00}));
                end else if (w[15:12] == 4'h8) begin
                    exp_q.push_back(ev(4'd3, {11'd0, w[11:9], 2'b01}));
                end else if (w[15:12] == 4'h9) begin
                    exp_q.push_back(ev(4'd4, {4'd0, 1'b0, w[7:0], 3'd0}));
                    exp_q.push_back(ev(4'd3, {11'd0, w[11:9], 2'b10}));
                end else if (w[15:12] == 4'hA) begin
                    exp_q.push_back(ev(4'd4, {4'd0, 1'b1, w[7:0], w[11:9]}));
                end else if (w[15:12] == 4'hF) begin
                    break;
                end else begin
                    exp_q.push_back(ev(4'd5, 16'd1));
                end
            end

            reset_dut();
            st = ev_q.size();
            mon_en = 1'b1;
            run = 1'b1; reset = 1'b1;
            guard = 0;
            while (!halted && guard < 600) begin
                tick(1);
                guard++;
            end
            tick(1);
            mon_en = 1'b0;
            chk($sformatf("t7 r%0d halt reached", r), halted, 1);
            chk($sformatf("t7 r%0d pc wrapped", r), bus.imem_addr, 0);
            chk($sformatf("t7 r%0d event count", r), ev_q.size() - st, exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                if (st + i < ev_q.size())
                    chk($sformatf("t7 r%0d event %0d", r, i), ev_q[st + i], exp_q[i]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
